// File: rtl/mac_ctrl_pkg.sv
// Shared types and default constants for the MAC sequencing controller.
package mac_ctrl_pkg;

  localparam int unsigned WIDTH_CNT_DEF = 5;
  localparam int unsigned PIPE_LAT_DEF  = 2;
  localparam int unsigned DRAIN_W       = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_cnt.sv
// Up-counter with synchronous clear; clear has priority over enable.
module mac_seq_ctrl_cnt #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             cnt_rst_i,
  input  logic             cnt_en_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk) begin
    if (cnt_rst_i) begin
      cnt_o <= '0;
    end else if (cnt_en_i) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one MAC job: clear accumulator, issue len operations, drain the pipe, pulse done.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_CNT = WIDTH_CNT_DEF,
  parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [WIDTH_CNT-1:0] len_i,
  input  logic                 stall_i,
  output logic                 busy_o,
  output logic                 acc_clr_o,
  output logic                 acc_en_o,
  output logic [WIDTH_CNT-1:0] addr_o,
  output logic                 done_o
);

  state_t               state;
  logic [WIDTH_CNT-1:0] len_q;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [WIDTH_CNT-1:0] op_cnt;
  logic                 busy_q;
  logic                 clr_q;
  logic                 done_q;
  logic                 last_issue;

  mac_seq_ctrl_cnt #(
    .WIDTH (WIDTH_CNT)
  ) u_op_cnt (
    .clk       (clk),
    .cnt_rst_i (~rst_n_i | (state == CLEAR)),
    .cnt_en_i  (acc_en_o),
    .cnt_o     (op_cnt)
  );

  // Issue follows operand availability directly so a stall costs exactly one cycle.
  assign acc_en_o   = (state == RUN) & ~stall_i;
  assign addr_o     = (state == RUN) ? op_cnt : '0;
  assign last_issue = acc_en_o && (op_cnt == len_q - WIDTH_CNT'(1));

  assign busy_o    = busy_q;
  assign acc_clr_o = clr_q;
  assign done_o    = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      len_q     <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            len_q  <= len_i;
            state  <= CLEAR;
            busy_q <= 1'b1;
            clr_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (last_issue) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed, table-driven bench for mac_seq_ctrl with default parameters.
module tb_mac_seq_ctrl;

  localparam int unsigned WIDTH_CNT = 5;
  localparam int unsigned PIPE_LAT  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n_i;
  logic                 start_i;
  logic [WIDTH_CNT-1:0] len_i;
  logic                 stall_i;
  logic                 busy_o;
  logic                 acc_clr_o;
  logic                 acc_en_o;
  logic [WIDTH_CNT-1:0] addr_o;
  logic                 done_o;

  int checks = 0;
  int errors = 0;

  logic [WIDTH_CNT-1:0] obs_addr [0:99];
  logic                 obs_en   [0:99];

  typedef struct {
    int          len;
    logic [63:0] smask;
    bit          hold;
    int          exp_done;
    int          exp_iss;
    int          exp_last;
  } vec_t;

  vec_t vecs [0:8];

  mac_seq_ctrl #(
    .WIDTH_CNT (WIDTH_CNT),
    .PIPE_LAT  (PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .len_i     (len_i),
    .stall_i   (stall_i),
    .busy_o    (busy_o),
    .acc_clr_o (acc_clr_o),
    .acc_en_o  (acc_en_o),
    .addr_o    (addr_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Caller is positioned just after a rising edge with the DUT in IDLE; cycle 0 is the accept cycle.
  task automatic run_job(input int len, input logic [63:0] smask, input bit hold,
                         input int exp_done, input int exp_iss, input int exp_last);
    int clr_c  = -1;
    int done_c = -1;
    int iss    = 0;
    int last   = 0;
    int viol   = 0;
    bit fin    = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      start_i = (c == 0) || hold;
      len_i   = (c == 0) ? WIDTH_CNT'(len) : WIDTH_CNT'($urandom);
      stall_i = (c < 64) ? smask[6'(c)] : 1'b0;
      @(negedge clk);
      obs_addr[c] = addr_o;
      obs_en[c]   = acc_en_o;
      if (c == 0) chk("idle_before_accept", 32'(busy_o), 32'd0);
      if (acc_clr_o && clr_c < 0) clr_c = c;
      if (acc_en_o) begin
        if (32'(addr_o) != 32'(iss)) viol++;
        last = 32'(addr_o);
        iss++;
      end
      if (acc_en_o && (stall_i || acc_clr_o || done_o || !busy_o)) viol++;
      if ((!busy_o || acc_clr_o || done_o) && addr_o != '0) viol++;
      if (done_o) begin
        done_c = c;
        fin    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("done_seen", 32'(fin), 32'd1);
    chk("clr_cycle", 32'(clr_c), 32'd1);
    chk("done_cycle", 32'(done_c), 32'(exp_done));
    chk("issue_count", 32'(iss), 32'(exp_iss));
    chk("last_addr", 32'(last), 32'(exp_last));
    chk("protocol_violations", 32'(viol), 32'd0);
  endtask

  initial begin
    int dn;
    vecs[0] = '{4,  64'h0,  1'b0, 8,  4,  3};
    vecs[1] = '{0,  64'h0,  1'b0, 2,  0,  0};
    vecs[2] = '{31, 64'h0,  1'b0, 35, 31, 30};
    vecs[3] = '{1,  64'h0,  1'b0, 5,  1,  0};
    vecs[4] = '{3,  64'h64, 1'b0, 10, 3,  2};
    vecs[5] = '{2,  64'h32, 1'b0, 6,  2,  1};
    vecs[6] = '{4,  64'h0,  1'b1, 8,  4,  3};
    vecs[7] = '{0,  64'h0,  1'b1, 2,  0,  0};
    vecs[8] = '{2,  64'h4,  1'b0, 7,  2,  1};

    rst_n_i = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_clr", 32'(acc_clr_o), 32'd0);
    chk("rst_en", 32'(acc_en_o), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].len, vecs[i].smask, vecs[i].hold,
              vecs[i].exp_done, vecs[i].exp_iss, vecs[i].exp_last);
      if (!vecs[i].hold) begin
        start_i = 1'b0;
        @(negedge clk);
        chk("idle_without_start", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
      end
    end

    // Stall during RUN holds the address and drops issue.
    run_job(4, 64'h18, 1'b0, 10, 4, 3);
    chk("stall_addr_c3", 32'(obs_addr[3]), 32'd1);
    chk("stall_en_c3", 32'(obs_en[3]), 32'd0);
    chk("stall_addr_c4", 32'(obs_addr[4]), 32'd1);
    chk("stall_en_c4", 32'(obs_en[4]), 32'd0);
    chk("stall_addr_c5", 32'(obs_addr[5]), 32'd1);
    chk("stall_en_c5", 32'(obs_en[5]), 32'd1);
    chk("stall_addr_c7", 32'(obs_addr[7]), 32'd3);
    start_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-RUN aborts without done, then a fresh job runs normally.
    start_i = 1'b1;
    len_i   = WIDTH_CNT'(4);
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n_i = 1'b0;
    @(negedge clk);
    chk("abort_running_en", 32'(acc_en_o), 32'd1);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_clr", 32'(acc_clr_o), 32'd0);
    chk("abort_en", 32'(acc_en_o), 32'd0);
    chk("abort_addr", 32'(addr_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o || busy_o) dn++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run_job(2, 64'h0, 1'b0, 6, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
